// File: rtl/scpu_pipe_pkg.sv
// scpu_pipe_pkg: shared constants and skid-state encoding for the SCPU inter-stage registers
package scpu_pipe_pkg;
  localparam int IDEX_CTRL_W = 12;
  localparam int IDEX_DATA_W = 137;
  localparam logic [IDEX_CTRL_W-1:0] BUBBLE_CTRL = '0;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} skid_state_e;
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: two-entry skid buffer with registered in_ready for full-throughput stages
module pipe_skid_buf
  import scpu_pipe_pkg::*;
#(
  parameter int CTRL_W = IDEX_CTRL_W,
  parameter int DATA_W = IDEX_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);
  skid_state_e       r_state;
  logic              r_in_ready;
  logic [CTRL_W-1:0] r_main_ctrl, r_skid_ctrl;
  logic [DATA_W-1:0] r_main_data, r_skid_data;
  logic              w_accept, w_emit;
  assign w_accept = in_valid & r_in_ready;
  assign w_emit   = (r_state != EMPTY) & out_ready;
  // main reg always holds the oldest beat; skid reg only fills when main is stuck
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_main_ctrl <= '0;
      r_skid_ctrl <= '0;
      r_main_data <= '0;
      r_skid_data <= '0;
    end else if (flush) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_main_ctrl <= CTRL_W'(BUBBLE_CTRL);
      r_skid_ctrl <= CTRL_W'(BUBBLE_CTRL);
    end else begin
      case (r_state)
        EMPTY: if (w_accept) begin
          r_state     <= ONE;
          r_main_ctrl <= in_ctrl;
          r_main_data <= in_data;
        end
        ONE: if (w_accept && !w_emit) begin
          r_state     <= FULL;
          r_in_ready  <= 1'b0;
          r_skid_ctrl <= in_ctrl;
          r_skid_data <= in_data;
        end else if (w_accept) begin
          r_main_ctrl <= in_ctrl;
          r_main_data <= in_data;
        end else if (w_emit) begin
          r_state <= EMPTY;
        end
        FULL: if (w_emit) begin
          r_state     <= ONE;
          r_in_ready  <= 1'b1;
          r_main_ctrl <= r_skid_ctrl;
          r_main_data <= r_skid_data;
        end
        default: begin
          r_state    <= EMPTY;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end
  assign in_ready  = r_in_ready;
  assign out_valid = r_state != EMPTY;
  assign out_ctrl  = r_main_ctrl;
  assign out_data  = r_main_data;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with stall, flush, optional skid and stall counter
module pipe_stage_reg
  import scpu_pipe_pkg::*;
#(
  parameter int CTRL_W = IDEX_CTRL_W,
  parameter int DATA_W = IDEX_DATA_W,
  parameter int SKID   = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic              w_valid, w_in_ready;
  logic [CTRL_W-1:0] w_ctrl;
  logic [DATA_W-1:0] w_data;
  logic [CNT_W-1:0]  r_stall_cnt;
  generate
    if (SKID != 0) begin : g_skid
      pipe_skid_buf #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .flush(flush),
        .out_valid(w_valid), .out_ready(out_ready), .out_ctrl(w_ctrl), .out_data(w_data)
      );
    end else begin : g_single
      logic              r_valid;
      logic [CTRL_W-1:0] r_ctrl;
      logic [DATA_W-1:0] r_data;
      assign w_in_ready = !r_valid | out_ready;
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_valid <= 1'b0;
          r_ctrl  <= '0;
          r_data  <= '0;
        end else if (flush) begin
          r_valid <= 1'b0;
          r_ctrl  <= CTRL_W'(BUBBLE_CTRL);
        end else if (in_valid && w_in_ready) begin
          r_valid <= 1'b1;
          r_ctrl  <= in_ctrl;
          r_data  <= in_data;
        end else if (out_ready) begin
          r_valid <= 1'b0;
        end
      end
      assign w_valid = r_valid;
      assign w_ctrl  = r_ctrl;
      assign w_data  = r_data;
    end
  endgenerate
  // saturating count of backpressured cycles; flush deliberately leaves it alone
  always_ff @(posedge clk) begin
    if (!rst) r_stall_cnt <= '0;
    else if (w_valid && !out_ready && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
  end
  assign in_ready  = w_in_ready;
  assign out_valid = w_valid;
  assign out_ctrl  = w_valid ? w_ctrl : CTRL_W'(BUBBLE_CTRL);
  assign out_data  = w_data;
  assign stall_cnt = r_stall_cnt;
endmodule
